// File: rtl/proc_io_bank.sv
// Buffered I/O bank: one FIFO per input and output channel between the
// processor core (strobe/address/stall) and external valid/ready streams.
module proc_io_bank #(
    parameter int NUBITS = 32,
    parameter int NUIOIN = 2,
    parameter int NUIOOU = 2,
    parameter int FDEPTH = 4,
    localparam int AWI = (NUIOIN > 1) ? $clog2(NUIOIN) : 1,
    localparam int AWO = (NUIOOU > 1) ? $clog2(NUIOOU) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     proc_req_in,
    input  logic [AWI-1:0]           proc_addr_in,
    output logic [NUBITS-1:0]        proc_in_data,
    input  logic                     proc_out_en,
    input  logic [AWO-1:0]           proc_addr_out,
    input  logic [NUBITS-1:0]        proc_out_data,
    output logic                     proc_stall,
    input  logic [NUIOIN*NUBITS-1:0] ext_in_data,
    input  logic [NUIOIN-1:0]        ext_in_valid,
    output logic [NUIOIN-1:0]        ext_in_ready,
    output logic [NUIOOU*NUBITS-1:0] ext_out_data,
    output logic [NUIOOU-1:0]        ext_out_valid,
    input  logic [NUIOOU-1:0]        ext_out_ready
);
    localparam int PW = $clog2(FDEPTH);
    localparam int CW = PW + 1;

    logic [NUIOIN-1:0] in_empty;
    logic [NUIOIN-1:0] in_pop;
    logic [NUBITS-1:0] in_head [NUIOIN];
    logic [NUIOOU-1:0] out_full;
    logic [NUIOOU-1:0] out_push;
    logic              rd_stall;
    logic              wr_stall;

    for (genvar i = 0; i < NUIOIN; i++) begin : g_in
        logic [NUBITS-1:0] mem [FDEPTH];
        logic [PW-1:0]     wp;
        logic [PW-1:0]     rp;
        logic [CW-1:0]     cnt;
        logic              push;

        // Ready looks only at the current count, never at a same-cycle pop.
        assign ext_in_ready[i] = (cnt != CW'(FDEPTH));
        assign in_empty[i]     = (cnt == '0);
        assign push            = ext_in_valid[i] & ext_in_ready[i];
        assign in_head[i]      = in_empty[i] ? '0 : mem[rp];

        always_ff @(posedge clk) begin
            if (push) mem[wp] <= ext_in_data[i*NUBITS +: NUBITS];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wp  <= '0;
                rp  <= '0;
                cnt <= '0;
            end else begin
                if (push) wp <= wp + 1'b1;
                if (in_pop[i]) rp <= rp + 1'b1;
                cnt <= cnt + CW'(push) - CW'(in_pop[i]);
            end
        end
    end

    for (genvar j = 0; j < NUIOOU; j++) begin : g_out
        logic [NUBITS-1:0] mem [FDEPTH];
        logic [PW-1:0]     wp;
        logic [PW-1:0]     rp;
        logic [CW-1:0]     cnt;
        logic              pop;

        assign out_full[j]      = (cnt == CW'(FDEPTH));
        assign ext_out_valid[j] = (cnt != '0);
        assign pop              = ext_out_valid[j] & ext_out_ready[j];
        assign ext_out_data[j*NUBITS +: NUBITS] =
            ext_out_valid[j] ? mem[rp] : '0;

        always_ff @(posedge clk) begin
            if (out_push[j]) mem[wp] <= proc_out_data;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wp  <= '0;
                rp  <= '0;
                cnt <= '0;
            end else begin
                if (out_push[j]) wp <= wp + 1'b1;
                if (pop) rp <= rp + 1'b1;
                cnt <= cnt + CW'(out_push[j]) - CW'(pop);
            end
        end
    end

    // Addresses matching no channel fall through: data 0, no stall.
    always_comb begin
        proc_in_data = '0;
        rd_stall     = 1'b0;
        in_pop       = '0;
        for (int i = 0; i < NUIOIN; i++) begin
            if (proc_req_in && proc_addr_in == AWI'(i)) begin
                if (in_empty[i]) begin
                    rd_stall = 1'b1;
                end else begin
                    proc_in_data = in_head[i];
                    in_pop[i]    = 1'b1;
                end
            end
        end
    end

    always_comb begin
        out_push = '0;
        wr_stall = 1'b0;
        for (int j = 0; j < NUIOOU; j++) begin
            if (proc_out_en && proc_addr_out == AWO'(j)) begin
                if (out_full[j]) wr_stall = 1'b1;
                else out_push[j] = 1'b1;
            end
        end
    end

    assign proc_stall = rd_stall | wr_stall;

endmodule

// File: tb/tb_proc_io_bank.sv
// Directed and randomized checks of proc_io_bank against a queue-based
// model of per-channel FIFO behaviour.
module tb_proc_io_bank;
    localparam int NB  = 32;
    localparam int NI  = 2;
    localparam int NO  = 3;
    localparam int DEP = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          proc_req_in;
    logic [0:0]    proc_addr_in;
    logic [NB-1:0] proc_in_data;
    logic          proc_out_en;
    logic [1:0]    proc_addr_out;
    logic [NB-1:0] proc_out_data;
    logic          proc_stall;
    logic [NI*NB-1:0] ext_in_data;
    logic [NI-1:0] ext_in_valid;
    logic [NI-1:0] ext_in_ready;
    logic [NO*NB-1:0] ext_out_data;
    logic [NO-1:0] ext_out_valid;
    logic [NO-1:0] ext_out_ready;

    int tests = 0;
    int fails = 0;

    logic [NB-1:0] inq [NI][$];
    logic [NB-1:0] outq [NO][$];

    proc_io_bank #(
        .NUBITS(NB), .NUIOIN(NI), .NUIOOU(NO), .FDEPTH(DEP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .proc_req_in(proc_req_in),
        .proc_addr_in(proc_addr_in),
        .proc_in_data(proc_in_data),
        .proc_out_en(proc_out_en),
        .proc_addr_out(proc_addr_out),
        .proc_out_data(proc_out_data),
        .proc_stall(proc_stall),
        .ext_in_data(ext_in_data),
        .ext_in_valid(ext_in_valid),
        .ext_in_ready(ext_in_ready),
        .ext_out_data(ext_out_data),
        .ext_out_valid(ext_out_valid),
        .ext_out_ready(ext_out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [NB-1:0] obs, logic [NB-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        proc_req_in   = 1'b0;
        proc_addr_in  = '0;
        proc_out_en   = 1'b0;
        proc_addr_out = '0;
        proc_out_data = '0;
        ext_in_data   = '0;
        ext_in_valid  = '0;
        ext_out_ready = '0;
    endtask

    task automatic check_all();
        logic [NB-1:0] ed;
        logic          es;
        int            a;
        ed = '0;
        es = 1'b0;
        a  = int'(proc_addr_in);
        if (proc_req_in && a < NI) begin
            if (inq[a].size() == 0) es = 1'b1;
            else ed = inq[a][0];
        end
        a = int'(proc_addr_out);
        if (proc_out_en && a < NO && outq[a].size() == DEP) es = 1'b1;
        chk("stall", NB'(proc_stall), NB'(es));
        chk("rd_data", proc_in_data, ed);
        for (int i = 0; i < NI; i++)
            chk("in_ready", NB'(ext_in_ready[i]), NB'(inq[i].size() < DEP));
        for (int j = 0; j < NO; j++) begin
            chk("out_valid", NB'(ext_out_valid[j]), NB'(outq[j].size() > 0));
            chk("out_data", ext_out_data[j*NB +: NB],
                (outq[j].size() > 0) ? outq[j][0] : '0);
        end
    endtask

    // Called just after a falling edge; inputs already driven.
    task automatic step();
        bit ipush [NI];
        bit ipop  [NI];
        bit opush [NO];
        bit opop  [NO];
        #1;
        check_all();
        for (int i = 0; i < NI; i++) begin
            ipush[i] = ext_in_valid[i] && inq[i].size() < DEP;
            ipop[i]  = proc_req_in && int'(proc_addr_in) == i
                       && inq[i].size() > 0;
        end
        for (int j = 0; j < NO; j++) begin
            opush[j] = proc_out_en && int'(proc_addr_out) == j
                       && outq[j].size() < DEP;
            opop[j]  = ext_out_ready[j] && outq[j].size() > 0;
        end
        @(posedge clk);
        for (int i = 0; i < NI; i++) begin
            if (ipop[i]) void'(inq[i].pop_front());
            if (ipush[i]) inq[i].push_back(ext_in_data[i*NB +: NB]);
        end
        for (int j = 0; j < NO; j++) begin
            if (opop[j]) void'(outq[j].pop_front());
            if (opush[j]) outq[j].push_back(proc_out_data);
        end
        @(negedge clk);
    endtask

    initial begin
        int got;
        idle();
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_ready", NB'(ext_in_ready), NB'(2'b11));
        chk("rst_ovalid", NB'(ext_out_valid), '0);
        rst = 1'b0;
        @(negedge clk);

        // Reset with three words held in IN0
        for (int k = 0; k < 3; k++) begin
            ext_in_valid = 2'b01;
            ext_in_data[0 +: NB] = NB'(32'hA0 + k);
            step();
        end
        idle();
        rst = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) inq[i].delete();
        for (int j = 0; j < NO; j++) outq[j].delete();
        @(negedge clk);
        rst = 1'b0;
        proc_req_in = 1'b0;
        #1;
        chk("t1_ready", NB'(ext_in_ready), NB'(2'b11));
        chk("t1_ovalid", NB'(ext_out_valid), '0);
        chk("t1_stall", NB'(proc_stall), '0);
        chk("t1_data", proc_in_data, '0);
        step();

        // Fill IN1, fifth word held off
        for (int k = 1; k <= 4; k++) begin
            ext_in_valid = 2'b10;
            ext_in_data[NB +: NB] = NB'(32'h11 * k);
            step();
        end
        ext_in_data[NB +: NB] = 32'h55;
        #1;
        chk("t2_full", NB'(ext_in_ready[1]), '0);
        step();
        idle();
        for (int k = 1; k <= 4; k++) begin
            proc_req_in  = 1'b1;
            proc_addr_in = 1'b1;
            #1;
            chk("t2_rd", proc_in_data, NB'(32'h11 * k));
            step();
        end
        idle();
        #1;
        chk("t2_ready", NB'(ext_in_ready[1]), NB'(1));
        step();

        // Read empty IN0 while 0xCAFE arrives
        proc_req_in = 1'b1;
        proc_addr_in = 1'b0;
        ext_in_valid = 2'b01;
        ext_in_data[0 +: NB] = 32'hCAFE;
        #1;
        chk("t3_stall", NB'(proc_stall), NB'(1));
        chk("t3_data0", proc_in_data, '0);
        step();
        ext_in_valid = '0;
        #1;
        chk("t3_nostall", NB'(proc_stall), '0);
        chk("t3_cafe", proc_in_data, 32'hCAFE);
        step();
        #1;
        chk("t3_popped", NB'(proc_stall), NB'(1));
        idle();
        step();

        // Overfill OUT1, then release one word
        for (int k = 1; k <= 4; k++) begin
            proc_out_en = 1'b1;
            proc_addr_out = 2'd1;
            proc_out_data = NB'(32'hB0 + k);
            step();
        end
        proc_out_data = 32'hB5;
        #1;
        chk("t4_stall", NB'(proc_stall), NB'(1));
        step();
        ext_out_ready = 3'b010;
        #1;
        chk("t4_popsame", NB'(proc_stall), NB'(1));
        step();
        ext_out_ready = '0;
        #1;
        chk("t4_free", NB'(proc_stall), '0);
        chk("t4_head", ext_out_data[NB +: NB], 32'hB2);
        step();
        idle();
        ext_out_ready = 3'b010;
        for (int k = 0; k < 4; k++) step();
        idle();
        #1;
        chk("t4_drained", NB'(ext_out_valid), '0);

        // Read pops while a write to a full channel stalls
        ext_in_valid = 2'b01;
        ext_in_data[0 +: NB] = 32'h5A5A;
        step();
        idle();
        for (int k = 0; k < 4; k++) begin
            proc_out_en = 1'b1;
            proc_addr_out = 2'd1;
            proc_out_data = NB'(k);
            step();
        end
        proc_req_in = 1'b1;
        proc_addr_in = 1'b0;
        #1;
        chk("t5_stall", NB'(proc_stall), NB'(1));
        chk("t5_rd", proc_in_data, 32'h5A5A);
        step();
        proc_out_en = 1'b0;
        #1;
        chk("t5_popped", NB'(proc_stall), NB'(1));
        idle();
        proc_out_en = 1'b1;
        proc_addr_out = 2'd3;
        proc_out_data = 32'hDEAD;
        #1;
        chk("t5_oob", NB'(proc_stall), '0);
        step();
        idle();
        #1;
        chk("t5_oobdrop", NB'(ext_out_valid), NB'(3'b010));
        ext_out_ready = '1;
        for (int k = 0; k < 4; k++) step();
        idle();

        // Wrap: 20 words through IN0 with random gaps
        got = 0;
        for (int k = 0, sent = 0; k < 400 && got < 20; k++) begin
            idle();
            if (sent < 20 && $urandom_range(0, 2) != 0) begin
                ext_in_valid = 2'b01;
                ext_in_data[0 +: NB] = 32'h1000 + NB'(sent);
            end
            if ($urandom_range(0, 2) != 0) proc_req_in = 1'b1;
            #1;
            if (ext_in_valid[0] && ext_in_ready[0]) sent++;
            if (proc_req_in && !proc_stall) begin
                chk("t6_order", proc_in_data, 32'h1000 + NB'(got));
                got++;
            end
            step();
        end
        chk("t6_count", NB'(got), NB'(20));

        // Fully random traffic on all channels
        for (int k = 0; k < 400; k++) begin
            proc_req_in   = 1'($urandom);
            proc_addr_in  = 1'($urandom);
            proc_out_en   = 1'($urandom);
            proc_addr_out = 2'($urandom);
            proc_out_data = $urandom;
            ext_in_data   = {$urandom, $urandom};
            ext_in_valid  = 2'($urandom);
            ext_out_ready = 3'($urandom);
            step();
        end
        idle();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
